// File: rtl/mac_pkg.sv
// Shared definitions for the multiply/accumulate path: default widths, FSM state type
// and block-length decode.
package mac_pkg;

  localparam int unsigned PROD_W = 8;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    ACCUM,
    HOLD
  } state_e;

  // A zero block length means the full 2^CNT_W products.
  function automatic logic [CNT_W:0] len_decode(input logic [CNT_W-1:0] len);
    return {(len == '0), len};
  endfunction

endpackage

// File: rtl/acc_adder.sv
// Accumulator adder: ACC_W-bit sum plus a zero-extended PROD_W product, with carry out.
module acc_adder #(
  parameter int unsigned PROD_W = 8,
  parameter int unsigned ACC_W  = 16
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              carry_o
);

  logic [ACC_W:0] prod_ext;
  logic [ACC_W:0] acc_ext;

  assign prod_ext = {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};
  assign acc_ext  = {1'b0, acc_i};

  assign {carry_o, sum_o} = acc_ext + prod_ext;

endmodule

// File: rtl/product_accumulator.sv
// Sums a programmable block of multiplier products and presents each block result,
// its product count and a sticky overflow flag over a valid/ready port.
module product_accumulator
  import mac_pkg::*;
#(
  parameter int unsigned PROD_W = mac_pkg::PROD_W,
  parameter int unsigned ACC_W  = mac_pkg::ACC_W,
  parameter int unsigned CNT_W  = mac_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [CNT_W-1:0]  blk_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W:0]    out_count,
  output logic              out_ovf
);

  localparam logic [CNT_W:0] CntOne = 1;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W:0]     cnt_q, cnt_d;
  logic [CNT_W:0]     len_q, len_d;
  logic               ovf_q, ovf_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [CNT_W:0]     count_q, count_d;
  logic               ovf_out_q, ovf_out_d;

  logic [ACC_W-1:0]   add_sum;
  logic               add_carry;
  logic [CNT_W:0]     len_cur;
  logic [CNT_W:0]     cnt_inc;

  acc_adder #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_acc_adder (
    .acc_i   (acc_q),
    .prod_i  (in_product),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  // Block length is latched on the first product only; later changes are ignored.
  assign len_cur = (cnt_q == '0) ? len_decode(blk_len) : len_q;
  assign cnt_inc = cnt_q + CntOne;

  assign in_ready  = rst_n && (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = sum_q;
  assign out_count = count_q;
  assign out_ovf   = ovf_out_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    sum_d     = sum_q;
    count_d   = count_q;
    ovf_out_d = ovf_out_q;

    if (clear) begin
      // Abort wins over both handshakes: offered product and held result are dropped.
      state_d   = ACCUM;
      acc_d     = '0;
      cnt_d     = '0;
      ovf_d     = 1'b0;
      sum_d     = '0;
      count_d   = '0;
      ovf_out_d = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (in_valid) begin
            len_d = len_cur;
            acc_d = add_sum;
            cnt_d = cnt_inc;
            ovf_d = ovf_q | add_carry;
            if (cnt_inc == len_cur) begin
              state_d   = HOLD;
              sum_d     = add_sum;
              count_d   = cnt_inc;
              ovf_out_d = ovf_q | add_carry;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      ovf_q     <= 1'b0;
      sum_q     <= '0;
      count_q   <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
      sum_q     <= sum_d;
      count_q   <= count_d;
      ovf_out_q <= ovf_out_d;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator; a narrow-accumulator copy shares all inputs
// so wrap and overflow can be observed alongside the default configuration.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [3:0]  blk_len;
  logic        in_valid;
  logic [7:0]  in_product;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_sum;
  logic [4:0]  out_count;
  logic        out_ovf;

  logic        n_in_ready;
  logic        n_out_valid;
  logic [9:0]  n_out_sum;
  logic [4:0]  n_out_count;
  logic        n_out_ovf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  product_accumulator u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .blk_len    (blk_len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_product (in_product),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_count  (out_count),
    .out_ovf    (out_ovf)
  );

  product_accumulator #(
    .ACC_W (10)
  ) u_dut_narrow (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .blk_len    (blk_len),
    .in_valid   (in_valid),
    .in_ready   (n_in_ready),
    .in_product (in_product),
    .out_valid  (n_out_valid),
    .out_ready  (out_ready),
    .out_sum    (n_out_sum),
    .out_count  (n_out_count),
    .out_ovf    (n_out_ovf)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one product and hold it until it transfers (bounded).
  task automatic push(input logic [7:0] p);
    int t = 0;
    in_valid   = 1'b1;
    in_product = p;
    while (!in_ready && t < 20) begin
      step();
      t++;
    end
    if (!in_ready) check_eq("push_ready", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    clear      = 1'b0;
    blk_len    = 4'd4;
    in_valid   = 1'b0;
    in_product = 8'h00;
    out_ready  = 1'b0;

    // 1: reset state, then a back-to-back block of four 0xE1
    step();
    step();
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check_eq("rst_out_sum", {16'b0, out_sum}, 32'd0);
    check_eq("rst_out_count", {27'b0, out_count}, 32'd0);
    check_eq("rst_out_ovf", {31'b0, out_ovf}, 32'd0);
    rst_n = 1'b1;
    step();
    check_eq("rel_in_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) push(8'hE1);
    check_eq("t1_not_yet_valid", {31'b0, out_valid}, 32'd0);
    push(8'hE1);
    check_eq("t1_out_valid", {31'b0, out_valid}, 32'd1);
    check_eq("t1_in_ready", {31'b0, in_ready}, 32'd0);
    check_eq("t1_sum", {16'b0, out_sum}, 32'h0384);
    check_eq("t1_count", {27'b0, out_count}, 32'd4);
    check_eq("t1_ovf", {31'b0, out_ovf}, 32'd0);
    accept();
    check_eq("t1_valid_drop", {31'b0, out_valid}, 32'd0);
    check_eq("t1_in_ready_back", {31'b0, in_ready}, 32'd1);

    // 2: blk_len=0 means 16; gaps and a mid-block blk_len change
    blk_len = 4'd0;
    for (int i = 0; i < 16; i++) begin
      push(8'h01);
      if (i == 0) blk_len = 4'd3;
      if (i != 15 && (i % 3) == 0) step();
      if (i == 14) check_eq("t2_not_early", {31'b0, out_valid}, 32'd0);
    end
    check_eq("t2_out_valid", {31'b0, out_valid}, 32'd1);
    check_eq("t2_sum", {16'b0, out_sum}, 32'h0010);
    check_eq("t2_count", {27'b0, out_count}, 32'd16);

    // 3: backpressure in HOLD keeps outputs stable
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t3_hold_sum", {16'b0, out_sum}, 32'h0010);
      check_eq("t3_hold_ready", {31'b0, in_ready}, 32'd0);
    end
    check_eq("t3_hold_valid", {31'b0, out_valid}, 32'd1);
    check_eq("t3_hold_count", {27'b0, out_count}, 32'd16);
    accept();
    check_eq("t3_rel_ready", {31'b0, in_ready}, 32'd1);
    blk_len = 4'd1;
    push(8'h07);
    check_eq("t3_fresh_sum", {16'b0, out_sum}, 32'h0007);
    check_eq("t3_fresh_count", {27'b0, out_count}, 32'd1);
    accept();

    // 4: narrow accumulator wraps and flags overflow; flag clears per block
    blk_len = 4'd5;
    for (int i = 0; i < 5; i++) push(8'hE1);
    check_eq("t4_wide_sum", {16'b0, out_sum}, 32'h0465);
    check_eq("t4_wide_ovf", {31'b0, out_ovf}, 32'd0);
    check_eq("t4_narrow_valid", {31'b0, n_out_valid}, 32'd1);
    check_eq("t4_narrow_sum", {22'b0, n_out_sum}, 32'h065);
    check_eq("t4_narrow_ovf", {31'b0, n_out_ovf}, 32'd1);
    check_eq("t4_narrow_count", {27'b0, n_out_count}, 32'd5);
    accept();
    blk_len = 4'd1;
    push(8'h02);
    check_eq("t4b_narrow_sum", {22'b0, n_out_sum}, 32'h002);
    check_eq("t4b_narrow_ovf", {31'b0, n_out_ovf}, 32'd0);
    accept();

    // 5: clear discards an offered product and a held result
    blk_len = 4'd4;
    push(8'h33);
    push(8'h33);
    clear      = 1'b1;
    in_valid   = 1'b1;
    in_product = 8'hFF;
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    check_eq("t5_clr_valid", {31'b0, out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) push(8'h10);
    check_eq("t5_no_early", {31'b0, out_valid}, 32'd0);
    push(8'h10);
    check_eq("t5_sum", {16'b0, out_sum}, 32'h0040);
    check_eq("t5_count", {27'b0, out_count}, 32'd4);
    clear     = 1'b1;
    out_ready = 1'b1;
    step();
    clear     = 1'b0;
    out_ready = 1'b0;
    check_eq("t5_hold_drop", {31'b0, out_valid}, 32'd0);
    check_eq("t5_hold_zero", {16'b0, out_sum}, 32'h0000);
    check_eq("t5_hold_cnt0", {27'b0, out_count}, 32'd0);
    check_eq("t5_ready", {31'b0, in_ready}, 32'd1);
    blk_len = 4'd1;
    push(8'h05);
    check_eq("t5_after_sum", {16'b0, out_sum}, 32'h0005);
    accept();

    // 6: reset mid-block
    blk_len = 4'd4;
    for (int i = 0; i < 3; i++) push(8'h20);
    rst_n = 1'b0;
    step();
    check_eq("t6_rst_valid", {31'b0, out_valid}, 32'd0);
    check_eq("t6_rst_sum", {16'b0, out_sum}, 32'd0);
    check_eq("t6_rst_count", {27'b0, out_count}, 32'd0);
    check_eq("t6_rst_ovf", {31'b0, out_ovf}, 32'd0);
    check_eq("t6_rst_ready", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b1;
    step();
    blk_len = 4'd2;
    push(8'h09);
    check_eq("t6_mid_valid", {31'b0, out_valid}, 32'd0);
    push(8'h04);
    check_eq("t6_valid", {31'b0, out_valid}, 32'd1);
    check_eq("t6_sum", {16'b0, out_sum}, 32'h000D);
    check_eq("t6_count", {27'b0, out_count}, 32'd2);
    accept();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
